sipo_frame_rx: RTL and testbench
================================

// Module: sipo_frame_rx
// PURPOSE
//  Serial-in/parallel-out frame receiver that consumes the 1-bit stream produced by the siso shift stage.
//  Detects a start bit, assembles WIDTH data bits MSB-first and checks the stop bit.
//  Presents each good word on a single-entry valid/ready output register.
//  Counts frame errors and overflows for debug.
// PARAMETERS
//  WIDTH     8   data bits per frame (>=2)
//  CNT_W     8   width of saturating error counter err_cnt
// PORTS
//  clk        in   1       single clock; all logic on posedge clk
//  rst        in   1       synchronous, active-high reset
//  sin        in   1       serial line, one bit sampled per clk; idles low
//  out_ready  in   1       downstream accepts out_data when high with out_valid
//  out_data   out  WIDTH   received word; stable while out_valid && !out_ready
//  out_valid  out  1       out_data holds an unconsumed word
//  busy       out  1       high in any state other than IDLE
//  frame_err  out  1       one-cycle pulse: bad stop bit (or parity, see CONFIGURATION)
//  overflow   out  1       one-cycle pulse: good word dropped, output register full
//  err_cnt    out  CNT_W   saturating count of frame_err + overflow pulses
// BEHAVIOUR
//  Frame format: start=1, then WIDTH data bits (MSB first), then [parity], then stop=0.
//  Reset: on rst=1 at a clk edge:
//   - state=IDLE; shift reg, bit counter, out_data, out_valid, busy, frame_err, overflow and err_cnt all cleared.
//   - sin in the reset cycle is ignored. A partial frame is discarded with no pulses.
//  FSM (one transition per clk):
//   IDLE:   sin=1 -> DATA, bit_cnt=0; else stay.
//   DATA:   shreg <= {shreg[WIDTH-2:0], sin}; bit_cnt++. After the WIDTH-th bit -> STOP (or PARITY if enabled).
//   PARITY: capture sin as parity bit -> STOP.
//   STOP:   always -> IDLE. sin=0 means the frame is good; sin=1 pulses frame_err and drops the word.
//  Back-to-back frames: a start bit may arrive the cycle after STOP. That cycle is IDLE and samples it.
//  Latency: start sampled at edge E gives out_valid=1 after edge E+WIDTH+1 (E+WIDTH+2 with parity).
//  Output register, on a good frame at STOP:
//   - load if !out_valid || out_ready (same-edge transfer plus reload keeps out_valid=1 with the new data).
//   - otherwise keep the old word, drop the new one and pulse overflow.
//   - out_valid clears only on out_valid && out_ready with no reload in that cycle.
//  Valid/ready: out_valid never deasserts and out_data never changes without a transfer, except on rst.
//  err_cnt: +1 per frame_err or overflow pulse; the two never pulse together. Holds at 2^CNT_W-1.
//  frame_err and overflow are registered and high for exactly one cycle, the cycle after the STOP edge.
// CONFIGURATION
//  SIPO_PARITY_EN defined:
//   - the PARITY state is present; the frame carries one even-parity bit after the data bits.
//   - the frame is good only if stop=0 and ^{data,parity}==0; otherwise frame_err pulses and the word is dropped.
//  SIPO_PARITY_EN undefined:
//   - no PARITY state and no parity bit; the stop bit directly follows the data bits.
// TESTING (WIDTH=8, CNT_W=8, macro off unless stated)
//  1. rst=1 for 2 clk, then sin=0 for 10 clk -> out_valid=0, busy=0, err_cnt=0, no pulses.
//  2. sin=1,1,0,1,0,0,1,0,1,0, out_ready=1 -> out_data=8'hA5, out_valid=1 for exactly 1 cycle, 10 cycles after start.
//  3. Frame 8'h3C with stop=1 -> frame_err pulses once, out_valid stays 0, err_cnt=1.
//  4. out_ready=0, frames 8'h3C then 8'hC3 back-to-back:
//     -> out_data stays 8'h3C, overflow pulses on the 2nd frame, err_cnt+1.
//     -> then out_ready=1 for one cycle -> out_valid=0.
//  5. rst pulsed during data bit 4 -> busy=0 next cycle, no pulses; following frame 8'hFF received as 8'hFF.
//  6. SIPO_PARITY_EN: 8'h07 with parity=1 -> accepted. Same word with parity=0 -> frame_err, no out_valid.

Source files
------------

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-in/parallel-out frame receiver.
// Frame on sin: start=1, WIDTH data bits MSB first, [even parity], stop=0.
// Good words land in a single-entry valid/ready output register; bad stop
// (or parity) and dropped words pulse frame_err / overflow and bump err_cnt.
// Optional feature: define SIPO_PARITY_EN to add the even-parity bit.
module sipo_frame_rx #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sin,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             busy,
   output logic             frame_err,
   output logic             overflow,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
`ifdef SIPO_PARITY_EN
   localparam logic [1:0] ST_PARITY = 2'd2;
`endif
   localparam logic [1:0] ST_STOP   = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic             frame_good;
   logic             frame_bad;
`ifdef SIPO_PARITY_EN
   logic             par_q, par_d;
`endif

   // Frame sequencing: start detect, MSB-first data shift, optional parity, stop.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
`ifdef SIPO_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (sin) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            shreg_d   = {shreg_q[WIDTH-2:0], sin};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef SIPO_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end
         end
`ifdef SIPO_PARITY_EN
         ST_PARITY: begin
            par_d   = sin;
            state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            // Always back to IDLE so a start bit on the very next cycle is seen.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Stop-bit (and parity) verdict, evaluated only in the STOP cycle.
   always_comb begin
`ifdef SIPO_PARITY_EN
      frame_good = (state_q == ST_STOP) && !sin && !(^{shreg_q, par_q});
`else
      frame_good = (state_q == ST_STOP) && !sin;
`endif
      frame_bad  = (state_q == ST_STOP) && !frame_good;
   end

   // Output register handshake, error pulses and saturating error counter.
   always_comb begin
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      frame_err_d = frame_bad;
      overflow_d  = 1'b0;
      err_cnt_d   = err_cnt_q;
      // Transfer first; a reload in the same cycle overrides the clear.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (frame_good) begin
         if (!out_valid_q || out_ready) begin
            out_data_d  = shreg_q;
            out_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end
      // frame_err and overflow are mutually exclusive, so +1 is enough.
      if ((frame_err_d || overflow_d) && (err_cnt_q != {CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + 1'b1;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         err_cnt_q   <= '0;
`ifdef SIPO_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
         err_cnt_q   <= err_cnt_d;
`ifdef SIPO_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != ST_IDLE);
   assign frame_err = frame_err_q;
   assign overflow  = overflow_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb_sipo_frame_rx: directed frames for sipo_frame_rx (WIDTH=8, CNT_W=8).
// Expected words are queued when a frame is issued; a negedge monitor pops
// and compares on every out_valid && out_ready transfer.
// Define SIPO_PARITY_EN for both bench and RTL to exercise the parity build.
module tb_sipo_frame_rx;

   logic       clk;
   logic       rst;
   logic       sin;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       busy;
   logic       frame_err;
   logic       overflow;
   logic [7:0] err_cnt;

   int checks   = 0;
   int failures = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   logic [7:0] exp_q[$];

   sipo_frame_rx #(.WIDTH(8), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .busy      (busy),
      .frame_err (frame_err),
      .overflow  (overflow),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
      end
   endtask

   // One bit per clock: drive, then step just past the sampling edge.
   task automatic send_bit(input logic b);
      sin = b;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame_p(input logic [7:0] d, input logic stop_bit, input logic par_bit);
      send_bit(1'b1);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
`ifdef SIPO_PARITY_EN
      send_bit(par_bit);
`endif
      send_bit(stop_bit);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      send_frame_p(d, stop_bit, ^d);
   endtask

   // Scoreboard monitor: pop on each transfer, tally error pulses.
   initial begin
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (frame_err) fe_cnt++;
            if (overflow)  ov_cnt++;
            if (frame_err && overflow) begin
               checks++;
               failures++;
               $display("FAIL pulse_overlap: frame_err and overflow both high @%0t", $time);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_unexpected: got word %0h, none expected @%0t", out_data, $time);
               end else begin
                  exp = exp_q.pop_front();
                  chk("sb_data", {24'h0, out_data}, {24'h0, exp});
                  $display("txn word=%02h expected=%02h @%0t", out_data, exp, $time);
               end
            end
         end
      end
   end

   // Watchdog: the directed run is short; anything this long is a hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish @%0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] w;
      rst       = 1'b1;
      sin       = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: reset state, then idle line.
      chk("rst_out_valid", {31'h0, out_valid}, 0);
      chk("rst_busy",      {31'h0, busy}, 0);
      chk("rst_err_cnt",   {24'h0, err_cnt}, 0);
      chk("rst_out_data",  {24'h0, out_data}, 0);
      chk("rst_pulses",    {30'h0, frame_err, overflow}, 0);
      for (int i = 0; i < 10; i++) begin
         send_bit(1'b0);
         chk("idle_busy", {31'h0, busy}, 0);
      end
      chk("idle_out_valid", {31'h0, out_valid}, 0);
      chk("idle_err_cnt",   {24'h0, err_cnt}, 0);
      chk("idle_pulses",    fe_cnt + ov_cnt, 0);

      // 2: A5 with latency and single-cycle valid.
      out_ready = 1'b1;
      w = 8'hA5;
      exp_q.push_back(8'hA5);
      send_bit(1'b1);
      chk("a5_busy", {31'h0, busy}, 1);
      for (int i = 7; i >= 0; i--) send_bit(w[i]);
`ifdef SIPO_PARITY_EN
      send_bit(^w);
`endif
      chk("a5_valid_early", {31'h0, out_valid}, 0);
      send_bit(1'b0);
      chk("a5_valid", {31'h0, out_valid}, 1);
      chk("a5_data",  {24'h0, out_data}, 32'hA5);
      chk("a5_busy_after", {31'h0, busy}, 0);
      send_bit(1'b0);
      chk("a5_valid_1cyc", {31'h0, out_valid}, 0);

      // 3: bad stop bit.
      send_frame(8'h3C, 1'b1);
      chk("fe_pulse", {31'h0, frame_err}, 1);
      send_bit(1'b0);
      chk("fe_pulse_1cyc", {31'h0, frame_err}, 0);
      chk("fe_count",  fe_cnt, 1);
      chk("fe_valid",  {31'h0, out_valid}, 0);
      chk("fe_err_cnt", {24'h0, err_cnt}, 1);

      // 4: back-to-back frames into a stalled output register.
      out_ready = 1'b0;
      exp_q.push_back(8'h3C);
      send_frame(8'h3C, 1'b0);
      send_frame(8'hC3, 1'b0);
      chk("ov_pulse", {31'h0, overflow}, 1);
      send_bit(1'b0);
      chk("ov_count",   ov_cnt, 1);
      chk("ov_data",    {24'h0, out_data}, 32'h3C);
      chk("ov_valid",   {31'h0, out_valid}, 1);
      chk("ov_err_cnt", {24'h0, err_cnt}, 2);
      out_ready = 1'b1;
      send_bit(1'b0);
      out_ready = 1'b0;
      chk("ov_drained", {31'h0, out_valid}, 0);

      // 5: reset in the middle of a frame, then a clean FF frame.
      out_ready = 1'b1;
      send_bit(1'b1);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      rst = 1'b1;
      send_bit(1'b1);
      rst = 1'b0;
      chk("mid_rst_busy",    {31'h0, busy}, 0);
      chk("mid_rst_pulses",  {30'h0, frame_err, overflow}, 0);
      chk("mid_rst_err_cnt", {24'h0, err_cnt}, 0);
      send_bit(1'b0);
      chk("mid_rst_idle", {31'h0, busy}, 0);
      exp_q.push_back(8'hFF);
      send_frame(8'hFF, 1'b0);
      chk("ff_valid", {31'h0, out_valid}, 1);
      chk("ff_data",  {24'h0, out_data}, 32'hFF);
      send_bit(1'b0);

`ifdef SIPO_PARITY_EN
      // 6: even parity accept / reject.
      exp_q.push_back(8'h07);
      send_frame_p(8'h07, 1'b0, 1'b1);
      chk("par_ok_valid", {31'h0, out_valid}, 1);
      chk("par_ok_data",  {24'h0, out_data}, 32'h07);
      send_bit(1'b0);
      send_frame_p(8'h07, 1'b0, 1'b0);
      chk("par_bad_fe",    {31'h0, frame_err}, 1);
      chk("par_bad_valid", {31'h0, out_valid}, 0);
      send_bit(1'b0);
      chk("par_bad_err_cnt", {24'h0, err_cnt}, 1);
`endif

      repeat (3) send_bit(1'b0);
      chk("sb_empty", exp_q.size(), 0);
      chk("final_valid", {31'h0, out_valid}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
